io_input_conditioner: RTL and testbench
=======================================

Name: io_input_conditioner

Overview:
- Front end for the board's physical inputs, directly upstream of the CPU IO block.
- Synchronises the 8 data switches and the 3 test switches to the CPU clock.
- Debounces the two "enter" push-buttons and turns each clean press into a single-cycle pulse.
- Drives the IO block's switch-value, test-value and enterA/enterB inputs.

Parameters:
- SW_WIDTH, 8, data switch width (drives io_input)
- TEST_WIDTH, 3, test switch width (drives test_input)
- SYNC_STAGES, 2, synchroniser flops per raw input; legal range 2..4
- DEBOUNCE_CYCLES, 20000, consecutive stable synchronised cycles needed to accept a button change; minimum 1
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
- clock  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sw_raw  in  SW_WIDTH  raw data switches
- test_raw  in  TEST_WIDTH  raw test switches
- btn_a_raw  in  1  raw enter-A button, active-high
- btn_b_raw  in  1  raw enter-B button, active-high
- io_input  out  SW_WIDTH  synchronised data switches
- test_input  out  TEST_WIDTH  synchronised test switches
- enterA  out  1  one-cycle pulse per accepted A press
- enterB  out  1  one-cycle pulse per accepted B press
- btn_a_level  out  1  debounced A level
- btn_b_level  out  1  debounced B level

Behaviour:
- Reset (async assert, release on the next clock edge):
  - all synchroniser flops, io_input and test_input = 0
  - enterA/enterB = 0, btn_*_level = 0
  - both debounce FSMs in S_LOW, counters = 0
- Synchronisers:
  - each raw bit passes through a SYNC_STAGES flop chain
  - io_input/test_input = last stage; no debounce on switches
  - raw change appears on the output exactly SYNC_STAGES cycles later
- Debounce FSM, one instance per button, input s = synchronised button:
  - S_LOW: level=0. s=1 -> S_RISE, cnt=1.
  - S_RISE: s=0 -> S_LOW, cnt=0. s=1 and cnt==DEBOUNCE_CYCLES -> S_HIGH, cnt=0, pulse=1 for that one cycle. Otherwise cnt++.
  - S_HIGH: level=1. s=0 -> S_FALL, cnt=1.
  - S_FALL: s=1 -> S_HIGH, cnt=0. s=0 and cnt==DEBOUNCE_CYCLES -> S_LOW, cnt=0, no pulse. Otherwise cnt++.
- Outputs:
  - enter* is a registered pulse, high exactly one cycle per S_RISE->S_HIGH transition
  - level is registered, equals (state==S_HIGH || state==S_FALL)
- Latency:
  - raw edge sampled at edge 0, held stable -> enter pulse high during the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1
  - level rises on the same edge as the pulse
- Boundary cases:
  - Bounce shorter than DEBOUNCE_CYCLES restarts the acceptance window and never produces a pulse.
  - A held button produces exactly one pulse; the next pulse requires a full release (S_LOW) first.
  - A and B are fully independent; a simultaneous press gives both pulses in the same cycle.
  - Counter never exceeds DEBOUNCE_CYCLES; no wrap.
  - Reset mid-debounce discards progress; a held button after release of rst_n gets a fresh pulse after the full latency.
  - Switch changes during a press are not qualified. io_input in the pulse cycle is whatever is synchronised at that cycle; the IO block latches it on enter*.

Decomposition:
- Shared package/defines holds:
  - FSM state encodings S_LOW=2'd0, S_RISE=2'd1, S_HIGH=2'd2, S_FALL=2'd3
  - default DEBOUNCE_CYCLES for the board clock
- One natural sub-module: btn_debounce (sync chain + FSM + counter + pulse), instantiated twice.
- Switch synchronisers stay inline in the top.

Test Plan:
- Sim with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
- Reset then idle -> all outputs 0, io_input=8'h00.
- sw_raw=8'hA5 at edge 0 -> io_input=8'hA5 from edge 2; test_raw=3'b101 -> test_input=3'b101 from edge 2.
- btn_a_raw rises at edge 0, held 20 cycles -> enterA high exactly one cycle after edge 7, btn_a_level=1 from edge 7; enterB stays 0.
- btn_a_raw toggles 1,0,1,0 each cycle for 8 cycles, then stays 0 -> no enterA; btn_a_level stays 0.
- btn_a_raw and btn_b_raw rise on the same edge, held -> enterA and enterB pulse on the same cycle. Release 3 cycles, re-press -> no new pulse. Release 10 cycles, re-press -> second pulse.
- Press A, assert rst_n=0 at edge 5 (mid S_RISE), release, keep A held -> no pulse before reset; one pulse 7 cycles after reset release.

Source files
------------

// File: rtl/io_input_conditioner_pkg.sv
// Shared definitions for the board input front end.
// Holds the debounce FSM encoding and the board-clock default timing values.
// Imported by the debounce sub-module and the top.
package io_input_conditioner_pkg;

    // Debounce FSM states: stable low, qualifying a rise, stable high, qualifying a fall
    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } deb_state_t;

    // Stable cycles needed before a button change is accepted at the board clock
    localparam int DEFAULT_DEBOUNCE_CYCLES = 20000;

    // Synchroniser depth per raw input (legal range 2..4)
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/io_input_conditioner_btn_debounce.sv
// Purpose: synchronise one raw push-button, debounce it, emit a level and a one-cycle press pulse.
// Latency: pulse/level rise SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first edge sampling a held press.
// Backpressure: none; free-running, the pulse is not held if the consumer ignores it.
module btn_debounce
    import io_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clock,
    input  logic rst_n,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    deb_state_t             state_q;
    deb_state_t             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   pulse_d;
    logic                   level_d;

    // Metastability chain: raw enters bit 0, the FSM only looks at the last stage
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // FSM state and stability counter registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: any disagreement during qualification restarts from the stable state,
    // and the counter saturates at CNT_MAX because that value always forces a transition
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (s) begin
                    state_d = S_RISE;
                    cnt_d   = CNT_ONE;
                end
            end
            S_RISE: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    state_d = S_FALL;
                    cnt_d   = CNT_ONE;
                end
            end
            S_FALL: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the transition so they can be registered and rise on the accepting edge
    always_comb begin
        pulse_d = (state_q == S_RISE) && s && (cnt_q == CNT_MAX);
        level_d = (state_d == S_HIGH) || (state_d == S_FALL);
    end

    // Registered pulse and level
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            pulse <= pulse_d;
            level <= level_d;
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Purpose: synchronise data/test switches and debounce the two enter buttons for the CPU IO block.
// Latency: switches SYNC_STAGES cycles; enter pulses SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
module io_input_conditioner
    import io_input_conditioner_pkg::*;
#(
    parameter int SW_WIDTH        = 8,
    parameter int TEST_WIDTH      = 3,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [SW_WIDTH-1:0]   sw_raw,
    input  logic [TEST_WIDTH-1:0] test_raw,
    input  logic                  btn_a_raw,
    input  logic                  btn_b_raw,
    output logic [SW_WIDTH-1:0]   io_input,
    output logic [TEST_WIDTH-1:0] test_input,
    output logic                  enterA,
    output logic                  enterB,
    output logic                  btn_a_level,
    output logic                  btn_b_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SW_WIDTH-1:0]   sw_sync_q   [SYNC_STAGES];
    logic [TEST_WIDTH-1:0] test_sync_q [SYNC_STAGES];

    // Switch synchronisers; switches are not debounced, the IO block samples them on enter
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_q[i]   <= '0;
                test_sync_q[i] <= '0;
            end
        end else begin
            sw_sync_q[0]   <= sw_raw;
            test_sync_q[0] <= test_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_q[i]   <= sw_sync_q[i-1];
                test_sync_q[i] <= test_sync_q[i-1];
            end
        end
    end

    assign io_input   = sw_sync_q[SYNC_STAGES-1];
    assign test_input = test_sync_q[SYNC_STAGES-1];

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_a (
        .clock (clock),
        .rst_n (rst_n),
        .raw   (btn_a_raw),
        .pulse (enterA),
        .level (btn_a_level)
    );

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn_b (
        .clock (clock),
        .rst_n (rst_n),
        .raw   (btn_b_raw),
        .pulse (enterB),
        .level (btn_b_level)
    );

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Inputs change 1 time unit after a rising edge (that edge is edge 0); outputs sampled on the falling edge.
// Expected pulse cycles are queued when a press is driven and matched when enter* is seen.
module tb_io_input_conditioner;

    localparam int SW_W  = 8;
    localparam int TST_W = 3;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int LAT   = SYNC + DEB + 1;

    logic             clock;
    logic             rst_n;
    logic [SW_W-1:0]  sw_raw;
    logic [TST_W-1:0] test_raw;
    logic             btn_a_raw;
    logic             btn_b_raw;
    logic [SW_W-1:0]  io_input;
    logic [TST_W-1:0] test_input;
    logic             enterA;
    logic             enterB;
    logic             btn_a_level;
    logic             btn_b_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_a_q[$];
    int exp_b_q[$];

    io_input_conditioner #(
        .SW_WIDTH        (SW_W),
        .TEST_WIDTH      (TST_W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .sw_raw      (sw_raw),
        .test_raw    (test_raw),
        .btn_a_raw   (btn_a_raw),
        .btn_b_raw   (btn_b_raw),
        .io_input    (io_input),
        .test_input  (test_input),
        .enterA      (enterA),
        .enterB      (enterB),
        .btn_a_level (btn_a_level),
        .btn_b_level (btn_b_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic test_reset;
        logic [15:0] obs;
        rst_n     = 1'b0;
        sw_raw    = '0;
        test_raw  = '0;
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        #3;
        obs = {io_input, test_input, enterA, enterB, btn_a_level, btn_b_level};
        total++;
        if (obs !== 16'h0) begin
            bad++;
            $display("FAIL reset_async outputs=%h want 0000", obs);
        end
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clock);
        obs = {io_input, test_input, enterA, enterB, btn_a_level, btn_b_level};
        total++;
        if (obs !== 16'h0) begin
            bad++;
            $display("FAIL reset_idle outputs=%h want 0000", obs);
        end
    endtask

    task automatic test_switches;
        logic [SW_W-1:0]  sw_tab  [4];
        logic [TST_W-1:0] tst_tab [4];
        logic [SW_W-1:0]  sw_old;
        logic [TST_W-1:0] tst_old;
        logic [SW_W-1:0]  sw_exp;
        logic [TST_W-1:0] tst_exp;
        sw_tab[0] = 8'hA5; tst_tab[0] = 3'b101;
        sw_tab[1] = 8'h5A; tst_tab[1] = 3'b010;
        sw_tab[2] = 8'hFF; tst_tab[2] = 3'b111;
        sw_tab[3] = 8'h00; tst_tab[3] = 3'b000;
        sw_old  = '0;
        tst_old = '0;
        for (int p = 0; p < 4; p++) begin
            @(posedge clock);
            #1;
            sw_raw   = sw_tab[p];
            test_raw = tst_tab[p];
            for (int k = 0; k < 4; k++) begin
                @(negedge clock);
                sw_exp  = (k >= SYNC) ? sw_tab[p]  : sw_old;
                tst_exp = (k >= SYNC) ? tst_tab[p] : tst_old;
                total++;
                if (io_input !== sw_exp) begin
                    bad++;
                    $display("FAIL sw_sync p=%0d edge=%0d io_input=%h want %h", p, k, io_input, sw_exp);
                end
                total++;
                if (test_input !== tst_exp) begin
                    bad++;
                    $display("FAIL test_sync p=%0d edge=%0d test_input=%b want %b", p, k, test_input, tst_exp);
                end
            end
            sw_old  = sw_tab[p];
            tst_old = tst_tab[p];
        end
    endtask

    task automatic test_press_a;
        int c0;
        int e;
        logic lvl_exp;
        @(posedge clock);
        #1;
        btn_a_raw = 1'b1;
        c0 = cyc;
        exp_a_q.push_back(c0 + LAT);
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (enterA) begin
                total++;
                if (exp_a_q.size() == 0) begin
                    bad++;
                    $display("FAIL press_a_extra enterA=1 at edge %0d want 0", cyc - c0);
                end else begin
                    e = exp_a_q.pop_front();
                    if (cyc !== e) begin
                        bad++;
                        $display("FAIL press_a_time enterA at edge %0d want edge %0d", cyc - c0, e - c0);
                    end
                end
            end
            total++;
            if (enterB !== 1'b0) begin
                bad++;
                $display("FAIL press_a_b_quiet enterB=%b want 0 at edge %0d", enterB, cyc - c0);
            end
            lvl_exp = (cyc - c0 >= LAT);
            total++;
            if (btn_a_level !== lvl_exp) begin
                bad++;
                $display("FAIL press_a_level level=%b want %b at edge %0d", btn_a_level, lvl_exp, cyc - c0);
            end
        end
        total++;
        if (exp_a_q.size() != 0) begin
            bad++;
            $display("FAIL press_a_missing pending=%0d want 0", exp_a_q.size());
            exp_a_q.delete();
        end
        btn_a_raw = 1'b0;
        repeat (15) @(negedge clock);
        total++;
        if (btn_a_level !== 1'b0) begin
            bad++;
            $display("FAIL press_a_release level=%b want 0", btn_a_level);
        end
    endtask

    task automatic test_bounce;
        for (int t = 0; t < 20; t++) begin
            @(posedge clock);
            #1;
            btn_a_raw = (t < 8) ? ((t % 2) == 0) : 1'b0;
            @(negedge clock);
            total++;
            if (enterA !== 1'b0) begin
                bad++;
                $display("FAIL bounce_pulse enterA=%b want 0 at t=%0d", enterA, t);
            end
            total++;
            if (btn_a_level !== 1'b0) begin
                bad++;
                $display("FAIL bounce_level level=%b want 0 at t=%0d", btn_a_level, t);
            end
        end
    endtask

    task automatic test_both;
        int c0;
        int rel;
        int e;
        logic lvl_exp;
        c0 = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clock);
            #1;
            if (t == 0) c0 = cyc;
            if (t == 0 || t == 15 || t == 40) begin
                btn_a_raw = 1'b1;
                btn_b_raw = 1'b1;
            end
            if (t == 12 || t == 30) begin
                btn_a_raw = 1'b0;
                btn_b_raw = 1'b0;
            end
            if (t == 0 || t == 40) begin
                exp_a_q.push_back(cyc + LAT);
                exp_b_q.push_back(cyc + LAT);
            end
            @(negedge clock);
            rel = cyc - c0;
            if (enterA) begin
                total++;
                if (exp_a_q.size() == 0) begin
                    bad++;
                    $display("FAIL both_a_extra enterA=1 at edge %0d want 0", rel);
                end else begin
                    e = exp_a_q.pop_front();
                    if (cyc !== e) begin
                        bad++;
                        $display("FAIL both_a_time enterA at edge %0d want edge %0d", rel, e - c0);
                    end
                end
            end
            if (enterB) begin
                total++;
                if (exp_b_q.size() == 0) begin
                    bad++;
                    $display("FAIL both_b_extra enterB=1 at edge %0d want 0", rel);
                end else begin
                    e = exp_b_q.pop_front();
                    if (cyc !== e) begin
                        bad++;
                        $display("FAIL both_b_time enterB at edge %0d want edge %0d", rel, e - c0);
                    end
                end
            end
            total++;
            if (enterA !== enterB) begin
                bad++;
                $display("FAIL both_same_cycle enterA=%b enterB=%b want equal at edge %0d", enterA, enterB, rel);
            end
            lvl_exp = (rel >= LAT && rel < 37) || (rel >= 40 + LAT);
            total++;
            if ({btn_a_level, btn_b_level} !== {lvl_exp, lvl_exp}) begin
                bad++;
                $display("FAIL both_level levels=%b%b want %b%b at edge %0d", btn_a_level, btn_b_level, lvl_exp, lvl_exp, rel);
            end
        end
        total++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            bad++;
            $display("FAIL both_missing pending a=%0d b=%0d want 0", exp_a_q.size(), exp_b_q.size());
            exp_a_q.delete();
            exp_b_q.delete();
        end
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
        repeat (15) @(negedge clock);
    endtask

    task automatic test_reset_mid;
        int c0;
        int rel;
        int e;
        logic lvl_exp;
        c0 = 0;
        for (int t = 0; t < 26; t++) begin
            @(posedge clock);
            #1;
            if (t == 0) begin
                c0 = cyc;
                btn_a_raw = 1'b1;
            end
            if (t == 5) rst_n = 1'b0;
            if (t == 7) begin
                rst_n = 1'b1;
                exp_a_q.push_back(cyc + LAT);
            end
            @(negedge clock);
            rel = cyc - c0;
            if (enterA) begin
                total++;
                if (exp_a_q.size() == 0) begin
                    bad++;
                    $display("FAIL rst_mid_extra enterA=1 at edge %0d want 0", rel);
                end else begin
                    e = exp_a_q.pop_front();
                    if (cyc !== e) begin
                        bad++;
                        $display("FAIL rst_mid_time enterA at edge %0d want edge %0d", rel, e - c0);
                    end
                end
            end
            lvl_exp = (rel >= 7 + LAT);
            total++;
            if (btn_a_level !== lvl_exp) begin
                bad++;
                $display("FAIL rst_mid_level level=%b want %b at edge %0d", btn_a_level, lvl_exp, rel);
            end
        end
        total++;
        if (exp_a_q.size() != 0) begin
            bad++;
            $display("FAIL rst_mid_missing pending=%0d want 0", exp_a_q.size());
            exp_a_q.delete();
        end
        btn_a_raw = 1'b0;
        repeat (15) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_switches();
        test_press_a();
        test_bounce();
        test_both();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
